ram_sync: RTL and testbench

Parametrised synchronous single-clock RAM with one write port, one registered read port and a built-in clear sequencer. After reset, a state machine sweeps every word to CLEAR_VALUE and holds off user traffic via busy. This is the CPU's data/program memory: a clocked, width/depth-generic replacement for the original 8x256 combinational memory.

---
 rtl/ram_sync.sv | 95 +++++++++
 tb/tb_ram_sync.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync.sv
// ram_sync: single-clock RAM with one write port, one registered read port
// and a built-in clear sequencer. After reset, every word is swept to
// CLEAR_VALUE. Until the sweep finishes, busy is high and user traffic is ignored.
module ram_sync #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DEPTH       = 256,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int                    BYPASS      = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Index width is just wide enough for DEPTH words. Because DEPTH never
    // exceeds 2^ADDR_WIDTH, this width is never wider than the address.
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_PTR  = (ADDR_WIDTH+1)'(DEPTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH:0]   clr_ptr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  same_address;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [IDX_WIDTH-1:0]  clr_idx;

    assign wr_in_range  = {1'b0, wr_address} < DEPTH_EXT;
    assign rd_in_range  = {1'b0, rd_address} < DEPTH_EXT;
    assign same_address = (wr_address == rd_address);
    assign wr_idx       = wr_address[IDX_WIDTH-1:0];
    assign rd_idx       = rd_address[IDX_WIDTH-1:0];
    assign clr_idx      = clr_ptr[IDX_WIDTH-1:0];
    assign busy         = (state == ST_CLEAR);

    // Clear sequencer: reset restarts the sweep; the edge that clears the last word enters READY
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_PTR) begin
                state <= ST_READY;
            end
        end
    end

    // Memory array: the clear sweep owns the write port until READY; out-of-range user writes are dropped
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_idx] <= CLEAR_VALUE;
            end else if (wr_en && wr_in_range) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

    // Registered read port: one-cycle latency; data holds when idle; same-address forwarding follows BYPASS
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (state == ST_READY && rd_en) begin
            rd_valid <= 1'b1;
            if (!rd_in_range) begin
                rd_data <= CLEAR_VALUE;
            end else if (BYPASS != 0 && wr_en && same_address) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_idx];
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: drives two ram_sync instances and checks them against an
// array-based model of the memory. Instance A uses the default 8x256 shape
// with bypass. Instance B uses a 16-bit x 10-word shape with 4-bit addresses,
// no bypass and CLEAR_VALUE = 0xBEEF.
module tb_ram_sync;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  rdEn;
    logic [1:0]  wrEn;
    logic [1:0][7:0]  rdAddr;
    logic [1:0][7:0]  wrAddr;
    logic [1:0][15:0] wrData;
    logic [1:0]  rdValid;
    logic [1:0]  busy;
    logic [7:0]  rdDataA;
    logic [15:0] rdDataB;

    int depthOf [2] = '{256, 10};
    int cvOf    [2] = '{0, 16'hBEEF};
    int bypOf   [2] = '{1, 0};
    int addrTop [2] = '{255, 15};

    int modelMem [2][256];
    int clearCnt [2];
    int expValid [2];
    int expData  [2];
    bit modelLive = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    ram_sync #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256),
        .CLEAR_VALUE(8'h00), .BYPASS(1)
    ) dutA (
        .clock(clock), .reset(reset),
        .rd_en(rdEn[0]), .rd_address(rdAddr[0]),
        .rd_data(rdDataA), .rd_valid(rdValid[0]),
        .wr_en(wrEn[0]), .wr_address(wrAddr[0]), .wr_data(wrData[0][7:0]),
        .busy(busy[0])
    );

    ram_sync #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(10),
        .CLEAR_VALUE(16'hBEEF), .BYPASS(0)
    ) dutB (
        .clock(clock), .reset(reset),
        .rd_en(rdEn[1]), .rd_address(rdAddr[1][3:0]),
        .rd_data(rdDataB), .rd_valid(rdValid[1]),
        .wr_en(wrEn[1]), .wr_address(wrAddr[1][3:0]), .wr_data(wrData[1]),
        .busy(busy[1])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input bit re, input int ra,
                                 input bit we, input int wa, input int wd);
        rdEn[k]   = re;
        rdAddr[k] = 8'(ra);
        wrEn[k]   = we;
        wrAddr[k] = 8'(wa);
        wrData[k] = 16'(wd);
    endtask

    task automatic idleAll();
        applyStimulus(0, 1'b0, 0, 1'b0, 0, 0);
        applyStimulus(1, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts clock edges until both instances drop busy, with a cycle bound
    task automatic measureBusy(output int nA, output int nB, input bit holdWrite);
        nA = -1;
        nB = -1;
        for (int c = 1; c <= 400; c++) begin
            if (holdWrite) applyStimulus(0, 1'b0, 0, 1'b1, 5, 8'hFF);
            tick();
            if (nA < 0 && !busy[0]) nA = c;
            if (nB < 0 && !busy[1]) nB = c;
            if (nA >= 0 && nB >= 0) break;
        end
        idleAll();
    endtask

    // Reference model. After reset the whole memory reads as CLEAR_VALUE.
    // Traffic is ignored for DEPTH edges after reset goes low. After that,
    // each read returns the stored word, or CLEAR_VALUE when the address is
    // out of range, or the new write data when bypass applies.
    always @(posedge clock) begin
        int ra, wa, wd;
        bit re, we;
        if (reset) modelLive = 1'b1;
        for (int k = 0; k < 2; k++) begin
            re = rdEn[k];
            we = wrEn[k];
            ra = (k == 0) ? int'(rdAddr[0]) : int'(rdAddr[1][3:0]);
            wa = (k == 0) ? int'(wrAddr[0]) : int'(wrAddr[1][3:0]);
            wd = (k == 0) ? int'(wrData[0][7:0]) : int'(wrData[1]);
            if (reset) begin
                clearCnt[k] = 0;
                expValid[k] = 0;
                expData[k]  = 0;
                for (int i = 0; i < 256; i++) modelMem[k][i] = cvOf[k];
            end else if (clearCnt[k] < depthOf[k]) begin
                clearCnt[k]++;
                expValid[k] = 0;
            end else begin
                if (re) begin
                    expValid[k] = 1;
                    if (ra >= depthOf[k])
                        expData[k] = cvOf[k];
                    else if (bypOf[k] != 0 && we && wa == ra)
                        expData[k] = wd;
                    else
                        expData[k] = modelMem[k][ra];
                end else begin
                    expValid[k] = 0;
                end
                if (we && wa < depthOf[k]) modelMem[k][wa] = wd;
            end
        end
    end

    // Compares both instances against the model on every falling edge once the model has seen a reset
    always @(negedge clock) begin
        if (modelLive) begin
            checkOutput("A busy", int'(busy[0]), int'(clearCnt[0] < depthOf[0]));
            checkOutput("A rd_valid", int'(rdValid[0]), expValid[0]);
            checkOutput("A rd_data", int'(rdDataA), expData[0]);
            checkOutput("B busy", int'(busy[1]), int'(clearCnt[1] < depthOf[1]));
            checkOutput("B rd_valid", int'(rdValid[1]), expValid[1]);
            checkOutput("B rd_data", int'(rdDataB), expData[1]);
        end
    end

    initial begin
        int nA, nB;
        reset = 1'b1;
        idleAll();
        tick();
        tick();
        checkOutput("reset busy A", int'(busy[0]), 1);
        checkOutput("reset rd_data B", int'(rdDataB), 0);
        checkOutput("reset rd_valid A", int'(rdValid[0]), 0);
        reset = 1'b0;

        measureBusy(nA, nB, 1'b0);
        checkOutput("busy cycles A", nA, 256);
        checkOutput("busy cycles B", nB, 10);

        for (int a = 0; a < 256; a++) begin
            applyStimulus(0, 1'b1, a, 1'b0, 0, 0);
            applyStimulus(1, 1'b1, a % 16, 1'b0, 0, 0);
            tick();
        end
        idleAll();
        tick();

        applyStimulus(1, 1'b1, 9, 1'b0, 0, 0);
        tick();
        checkOutput("B read 9", int'(rdDataB), 16'hBEEF);

        applyStimulus(0, 1'b0, 0, 1'b1, 8'h10, 8'hA5);
        applyStimulus(1, 1'b0, 0, 1'b1, 4'hC, 16'h1234);
        tick();
        applyStimulus(0, 1'b1, 8'h10, 1'b0, 0, 0);
        applyStimulus(1, 1'b1, 4'hC, 1'b0, 0, 0);
        tick();
        checkOutput("A read 0x10", int'(rdDataA), 8'hA5);
        checkOutput("A valid 0x10", int'(rdValid[0]), 1);
        checkOutput("B read 0xC", int'(rdDataB), 16'hBEEF);
        checkOutput("B valid 0xC", int'(rdValid[1]), 1);
        idleAll();
        tick();
        checkOutput("A valid drop", int'(rdValid[0]), 0);
        checkOutput("A data hold", int'(rdDataA), 8'hA5);

        applyStimulus(0, 1'b1, 8'h20, 1'b1, 8'h20, 8'h3C);
        applyStimulus(1, 1'b1, 2, 1'b1, 2, 8'h3C);
        tick();
        checkOutput("A bypass", int'(rdDataA), 8'h3C);
        checkOutput("B no bypass", int'(rdDataB), 16'hBEEF);
        applyStimulus(0, 1'b0, 0, 1'b0, 0, 0);
        applyStimulus(1, 1'b1, 2, 1'b0, 0, 0);
        tick();
        checkOutput("B after write", int'(rdDataB), 8'h3C);
        idleAll();

        for (int a = 0; a < 8; a++) begin
            applyStimulus(0, 1'b0, 0, 1'b1, a, a * 3);
            tick();
        end
        for (int a = 0; a < 8; a++) begin
            applyStimulus(0, 1'b1, a, 1'b0, 0, 0);
            tick();
            checkOutput($sformatf("burst data %0d", a), int'(rdDataA), a * 3);
            checkOutput($sformatf("burst valid %0d", a), int'(rdValid[0]), 1);
        end
        idleAll();
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        measureBusy(nA, nB, 1'b1);
        checkOutput("busy after mid-clear reset", nA, 256);
        applyStimulus(0, 1'b1, 5, 1'b0, 0, 0);
        tick();
        checkOutput("write during busy", int'(rdDataA), 0);
        applyStimulus(0, 1'b1, 8'h10, 1'b0, 0, 0);
        tick();
        checkOutput("re-cleared 0x10", int'(rdDataA), 0);
        idleAll();

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                int hi;
                hi = ($urandom_range(0, 1) == 0) ? 3 : addrTop[k];
                applyStimulus(k, 1'($urandom_range(0, 1)), $urandom_range(0, hi),
                              1'($urandom_range(0, 1)), $urandom_range(0, hi),
                              int'($urandom_range(0, 65535)));
            end
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;
        idleAll();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
